// File: rtl/key_expansion_seq.sv
// AES key-expansion engine that generates one schedule word per cycle. It keeps only the
// last Nk words in a sliding window. Every fourth word completes a 128-bit round key,
// which is presented on a valid/ready handshake. Four shared SubTable S-boxes perform
// SubWord. The SubTable S-box is defined at the end of this file.
module key_expansion_seq #(
   parameter int KEY_BITS = 128
) (
   input  logic                clk,
   input  logic                rstN,
   input  logic                start,
   input  logic [KEY_BITS-1:0] keyIn,
   output logic                busy,
   output logic [127:0]        roundKey,
   output logic                roundKeyValid,
   input  logic                roundKeyReady,
   output logic [3:0]          roundIdx,
   output logic                done
);

   localparam int NK = KEY_BITS / 32;
   localparam int NR = NK + 6;
   localparam int NW = 4 * (NR + 1);
   localparam logic [5:0] LAST_IDX = 6'(NW - 1);
   localparam logic [5:0] NK_IDX   = 6'(NK);
   localparam logic [2:0] NK_LAST  = 3'(NK - 1);

   generate
      if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
         $error("key_expansion_seq: KEY_BITS must be 128, 192 or 256");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GEN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t        state_q;
   logic [5:0]    idx_q;        // word index i of the next word to generate
   logic [2:0]    mod_q;        // i mod Nk
   logic [7:0]    rcon_q;       // Rcon byte for the next i mod Nk == 0 word
   logic [31:0]   win_q [NK];   // last Nk words, oldest at index 0
   logic [95:0]   asm_q;        // first three words of the round key being built
   logic [127:0]  key_q;
   logic [3:0]    ridx_q;
   logic          valid_q;
   logic          done_q;
   logic          busy_q;

   logic [31:0]   prev_word;
   logic [31:0]   sbox_in;
   logic [31:0]   sbox_out;
   logic [31:0]   t_word;
   logic [31:0]   next_word_d;
   logic          stall;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   assign prev_word = win_q[NK-1];

   // A completed round key cannot be loaded while the previous one is still unaccepted
   always_comb begin
      stall = 1'b0;
      if (state_q == GEN && idx_q[1:0] == 2'b11 && valid_q && !roundKeyReady) begin
         stall = 1'b1;
      end else begin
         stall = 1'b0;
      end
   end

   // SubWord input: rotated previous word on Nk boundaries, plain previous word otherwise
   always_comb begin
      sbox_in = prev_word;
      if (mod_q == 3'd0) begin
         sbox_in = {prev_word[23:0], prev_word[31:24]};
      end else begin
         sbox_in = prev_word;
      end
   end

   SubTable u_sbox0 (.in_i(sbox_in[7:0]),   .out_o(sbox_out[7:0]));
   SubTable u_sbox1 (.in_i(sbox_in[15:8]),  .out_o(sbox_out[15:8]));
   SubTable u_sbox2 (.in_i(sbox_in[23:16]), .out_o(sbox_out[23:16]));
   SubTable u_sbox3 (.in_i(sbox_in[31:24]), .out_o(sbox_out[31:24]));

   // Schedule transform t applied to w[i-1], and the next word w[i]
   always_comb begin
      t_word      = prev_word;
      next_word_d = win_q[0];
      if (mod_q == 3'd0) begin
         t_word = sbox_out ^ {rcon_q, 24'h000000};
      end else if (NK == 8 && mod_q == 3'd4) begin
         t_word = sbox_out;
      end else begin
         t_word = prev_word;
      end
      // While i < Nk the window is simply rotated, so its head is key word i
      if (idx_q < NK_IDX) begin
         next_word_d = win_q[0];
      end else begin
         next_word_d = win_q[0] ^ t_word;
      end
   end

   // Control FSM, word generation, window, assembly and registered round-key outputs
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q <= IDLE;
         idx_q   <= 6'd0;
         mod_q   <= 3'd0;
         rcon_q  <= 8'h00;
         for (int k = 0; k < NK; k++) begin
            win_q[k] <= 32'h00000000;
         end
         asm_q   <= 96'h0;
         key_q   <= 128'h0;
         ridx_q  <= 4'd0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= GEN;
                  busy_q  <= 1'b1;
                  idx_q   <= 6'd0;
                  mod_q   <= 3'd0;
                  rcon_q  <= 8'h01;
                  asm_q   <= 96'h0;
                  for (int k = 0; k < NK; k++) begin
                     win_q[k] <= keyIn[KEY_BITS-1-32*k -: 32];
                  end
               end else begin
                  state_q <= IDLE;
               end
            end
            GEN: begin
               if (stall) begin
                  state_q <= GEN;
               end else begin
                  for (int k = 0; k < NK - 1; k++) begin
                     win_q[k] <= win_q[k+1];
                  end
                  win_q[NK-1] <= next_word_d;
                  idx_q <= idx_q + 6'd1;
                  mod_q <= (mod_q == NK_LAST) ? 3'd0 : mod_q + 3'd1;
                  if (mod_q == 3'd0 && idx_q >= NK_IDX) begin
                     rcon_q <= xtime(rcon_q);
                  end else begin
                     rcon_q <= rcon_q;
                  end
                  if (idx_q[1:0] == 2'b11) begin
                     key_q   <= {asm_q, next_word_d};
                     ridx_q  <= idx_q[5:2];
                     valid_q <= 1'b1;
                  end else begin
                     asm_q <= {asm_q[63:0], next_word_d};
                     if (valid_q && roundKeyReady) begin
                        valid_q <= 1'b0;
                     end else begin
                        valid_q <= valid_q;
                     end
                  end
                  if (idx_q == LAST_IDX) begin
                     state_q <= DRAIN;
                  end else begin
                     state_q <= GEN;
                  end
               end
            end
            DRAIN: begin
               if (valid_q && roundKeyReady) begin
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end else begin
                  state_q <= DRAIN;
               end
            end
            default: begin
               state_q <= IDLE;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy          = busy_q;
   assign roundKey      = key_q;
   assign roundKeyValid = valid_q;
   assign roundIdx      = ridx_q;
   assign done          = done_q;

endmodule

// AES forward S-box computed as the GF(2^8) inverse followed by the affine transform
module SubTable (
   input  logic [7:0] in_i,
   output logic [7:0] out_o
);

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) begin
            p = p ^ aa;
         end
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      gf_mul = p;
   endfunction

   // x^254 is the multiplicative inverse, and it maps 0 to 0 as the S-box requires
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] e;
      e = gf_mul(x, x);              // x^2
      e = gf_mul(e, x);              // x^3
      e = gf_mul(gf_mul(e, e), x);   // x^7
      e = gf_mul(gf_mul(e, e), x);   // x^15
      e = gf_mul(gf_mul(e, e), x);   // x^31
      e = gf_mul(gf_mul(e, e), x);   // x^63
      e = gf_mul(gf_mul(e, e), x);   // x^127
      gf_inv = gf_mul(e, e);         // x^254
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] b;
      b = gf_inv(x);
      sbox = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   // Pure combinational substitution
   always_comb begin
      out_o = sbox(in_i);
   end

endmodule

// File: tb/tb_key_expansion_seq.sv
// Directed, table-driven bench for key_expansion_seq using the FIPS-197 key schedules
module tb_key_expansion_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rstN;

   logic s128, b128, v128, r128, d128;
   logic [127:0] k128, rk128;
   logic [3:0] ix128;

   logic s192, b192, v192, r192, d192;
   logic [191:0] k192;
   logic [127:0] rk192;
   logic [3:0] ix192;

   logic s256, b256, v256, r256, d256;
   logic [255:0] k256;
   logic [127:0] rk256;
   logic [3:0] ix256;

   key_expansion_seq #(.KEY_BITS(128)) u_d128 (
      .clk(clk), .rstN(rstN), .start(s128), .keyIn(k128), .busy(b128), .roundKey(rk128),
      .roundKeyValid(v128), .roundKeyReady(r128), .roundIdx(ix128), .done(d128));
   key_expansion_seq #(.KEY_BITS(192)) u_d192 (
      .clk(clk), .rstN(rstN), .start(s192), .keyIn(k192), .busy(b192), .roundKey(rk192),
      .roundKeyValid(v192), .roundKeyReady(r192), .roundIdx(ix192), .done(d192));
   key_expansion_seq #(.KEY_BITS(256)) u_d256 (
      .clk(clk), .rstN(rstN), .start(s256), .keyIn(k256), .busy(b256), .roundKey(rk256),
      .roundKeyValid(v256), .roundKeyReady(r256), .roundIdx(ix256), .done(d256));

   typedef struct {
      logic [3:0]   idx;
      logic [127:0] key;
      int           cyc;
   } cap_t;

   typedef struct {
      logic [3:0]   idx;
      logic [127:0] key;
      int           off;
   } vec_t;

   cap_t q128[$];
   cap_t q192[$];
   cap_t q256[$];
   int   cyc = 0;
   int   dcnt128 = 0;
   int   dcyc128 = 0;
   int   dcyc192 = 0;
   int   dcyc256 = 0;
   logic [1:0] dbv128 = 2'b11;

   vec_t tbl[11];
   int   total = 0;
   int   bad = 0;
   int   st = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every accepted round key and every done pulse of each instance
   always @(negedge clk) begin
      if (v128 && r128) q128.push_back('{ix128, rk128, cyc});
      if (v192 && r192) q192.push_back('{ix192, rk192, cyc});
      if (v256 && r256) q256.push_back('{ix256, rk256, cyc});
      if (d128) begin
         dcnt128 <= dcnt128 + 1;
         dcyc128 <= cyc;
         dbv128  <= {b128, v128};
      end
      if (d192) dcyc192 <= cyc;
      if (d256) dcyc256 <= cyc;
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      total = total + 1;
      if (act != exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      total = total + 1;
      bad = bad + 1;
      $display("FAIL %s: timed out", name);
   endtask

   task automatic zero128(input string tag);
      chki({tag, " busy"}, int'(b128), 0);
      chki({tag, " valid"}, int'(v128), 0);
      chki({tag, " done"}, int'(d128), 0);
      chki({tag, " idx"}, int'(ix128), 0);
      chk({tag, " key"}, rk128, 128'h0);
   endtask

   task automatic do_start(input int sel, input logic [255:0] key);
      @(posedge clk); #1;
      if (sel == 0) begin s128 = 1'b1; k128 = key[127:0]; end
      else if (sel == 1) begin s192 = 1'b1; k192 = key[191:0]; end
      else begin s256 = 1'b1; k256 = key; end
      @(posedge clk); #1;
      s128 = 1'b0; s192 = 1'b0; s256 = 1'b0;
      st = cyc;
   endtask

   task automatic wait_round128(input int idx);
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 300 && !ok; n++) begin
         @(negedge clk);
         ok = v128 && (int'(ix128) == idx);
      end
      if (!ok) timeout($sformatf("wait round %0d", idx));
   endtask

   task automatic wait_done(input int sel);
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 400 && !ok; n++) begin
         @(negedge clk);
         ok = (sel == 0) ? d128 : (sel == 1) ? d192 : d256;
      end
      if (!ok) timeout($sformatf("wait done %0d", sel));
      @(posedge clk); #1;
   endtask

   task automatic check_run128(input string tag, input int base, input bit with_off);
      chki({tag, " count"}, q128.size() - base, 11);
      for (int r = 0; r < 11; r++) begin
         if (base + r < q128.size()) begin
            chki($sformatf("%s r%0d idx", tag, r), int'(q128[base+r].idx), int'(tbl[r].idx));
            chk($sformatf("%s r%0d key", tag, r), q128[base+r].key, tbl[r].key);
            if (with_off)
               chki($sformatf("%s r%0d lat", tag, r), q128[base+r].cyc - st, tbl[r].off);
         end
      end
   endtask

   localparam logic [127:0] KEY128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   initial begin
      int base;
      int dbase;
      bit seen;

      tbl[0]  = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c, 4};
      tbl[1]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605, 8};
      tbl[2]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f, 12};
      tbl[3]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b, 16};
      tbl[4]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00, 20};
      tbl[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc, 24};
      tbl[6]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd, 28};
      tbl[7]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f, 32};
      tbl[8]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f, 36};
      tbl[9]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e, 40};
      tbl[10] = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 44};

      rstN = 1'b0;
      s128 = 1'b0; s192 = 1'b0; s256 = 1'b0;
      k128 = '0; k192 = '0; k256 = '0;
      r128 = 1'b1; r192 = 1'b1; r256 = 1'b1;

      // reset state, and outputs quiet after release
      #12;
      zero128("reset");
      @(negedge clk); rstN = 1'b1;
      repeat (3) @(negedge clk);
      zero128("post-reset idle");

      // ready tied high: FIPS-197 A.1 sequence with exact latencies
      base = q128.size();
      do_start(0, {128'h0, KEY128});
      wait_done(0);
      check_run128("basic", base, 1'b1);
      chki("basic done latency", dcyc128 - st, 45);
      chki("basic busy/valid at done", int'(dbv128), 0);

      // backpressure: 7 stalled cycles on round 3, then random ready
      base = q128.size();
      do_start(0, {128'h0, KEY128});
      wait_round128(2);
      @(posedge clk); #1; r128 = 1'b0;
      wait_round128(3);
      for (int c = 0; c < 7; c++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chki($sformatf("stall c%0d valid", c), int'(v128), 1);
         chki($sformatf("stall c%0d idx", c), int'(ix128), 3);
         chk($sformatf("stall c%0d key", c), rk128, tbl[3].key);
      end
      seen = 1'b0;
      for (int n = 0; n < 600 && !seen; n++) begin
         @(posedge clk); #1;
         r128 = 1'($urandom_range(0, 1));
         @(negedge clk);
         seen = d128;
      end
      if (!seen) timeout("backpressure done");
      @(posedge clk); #1; r128 = 1'b1;
      check_run128("bp", base, 1'b0);

      // reset while stalled on round 5, then a fresh run
      do_start(0, {128'h0, KEY128});
      wait_round128(4);
      @(posedge clk); #1; r128 = 1'b0;
      wait_round128(5);
      @(posedge clk); #2;
      rstN = 1'b0;
      #1;
      zero128("mid reset");
      @(negedge clk); rstN = 1'b1; r128 = 1'b1;
      repeat (3) @(negedge clk);
      zero128("after mid reset");
      base = q128.size();
      do_start(0, {128'h0, KEY128});
      wait_done(0);
      check_run128("restart", base, 1'b1);

      // second start at round 4 while busy is ignored
      base = q128.size();
      dbase = dcnt128;
      do_start(0, {128'h0, KEY128});
      wait_round128(4);
      @(posedge clk); #1; s128 = 1'b1; k128 = 128'h0;
      @(posedge clk); #1; s128 = 1'b0;
      wait_done(0);
      repeat (12) @(negedge clk);
      check_run128("restart-ignored", base, 1'b1);
      chki("single done pulse", dcnt128 - dbase, 1);
      chki("idle busy", int'(b128), 0);

      // 192-bit key
      do_start(1, {64'h0, 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b});
      wait_done(1);
      chki("k192 count", q192.size(), 13);
      for (int r = 0; r < 13; r++)
         if (r < q192.size()) chki($sformatf("k192 r%0d idx", r), int'(q192[r].idx), r);
      if (q192.size() == 13) begin
         chk("k192 r0", q192[0].key, 128'h8e73b0f7da0e6452c810f32b809079e5);
         chk("k192 r1 hi", {64'h0, q192[1].key[127:64]}, {64'h0, 64'h62f8ead2522c6b7b});
         chk("k192 r12", q192[12].key, 128'he98ba06f448c773c8ecc720401002202);
         chki("k192 r12 lat", q192[12].cyc - st, 52);
      end
      chki("k192 done latency", dcyc192 - st, 53);

      // 256-bit key
      do_start(2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4);
      wait_done(2);
      chki("k256 count", q256.size(), 15);
      for (int r = 0; r < 15; r++)
         if (r < q256.size()) chki($sformatf("k256 r%0d idx", r), int'(q256[r].idx), r);
      if (q256.size() == 15) begin
         chk("k256 r0", q256[0].key, 128'h603deb1015ca71be2b73aef0857d7781);
         chk("k256 r1", q256[1].key, 128'h1f352c073b6108d72d9810a30914dff4);
         chk("k256 r14", q256[14].key, 128'hfe4890d1e6188d0b046df344706c631e);
      end
      chki("k256 done latency", dcyc256 - st, 61);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
